// File: rtl/svx32_dmem_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : svx32_dmem_arbiter
// Brief    : Two-master round-robin arbiter for the sparrowx32 data-memory port.
//            Optional watchdog abort enabled by defining SVX32_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module svx32_dmem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                pil_clk,
  input  logic                pil_rst_n,
  input  logic                pil_m0_mem_req,
  input  logic                pil_m0_mem_wen,
  input  logic [ADDR_W-1:0]   piv_m0_mem_addr,
  input  logic [DATA_W-1:0]   piv_m0_mem_wdata,
  input  logic [DATA_W/8-1:0] piv_m0_mem_byte_sel,
  output logic                pol_m0_mem_ack,
  output logic                pol_m0_mem_valid,
  output logic [DATA_W-1:0]   pov_m0_mem_rdata,
  input  logic                pil_m1_mem_req,
  input  logic                pil_m1_mem_wen,
  input  logic [ADDR_W-1:0]   piv_m1_mem_addr,
  input  logic [DATA_W-1:0]   piv_m1_mem_wdata,
  input  logic [DATA_W/8-1:0] piv_m1_mem_byte_sel,
  output logic                pol_m1_mem_ack,
  output logic                pol_m1_mem_valid,
  output logic [DATA_W-1:0]   pov_m1_mem_rdata,
  output logic                pol_mem_req,
  output logic                pol_mem_wen,
  output logic [ADDR_W-1:0]   pov_mem_addr,
  output logic [DATA_W-1:0]   pov_mem_wdata,
  output logic [DATA_W/8-1:0] pov_mem_byte_sel,
  input  logic                pil_mem_ack,
  input  logic                pil_mem_valid,
  input  logic [DATA_W-1:0]   piv_mem_rdata,
  output logic [1:0]          pov_grant,
  output logic                pol_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_rr_ptr;
  logic [1:0]          r_grant;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_byte_sel;

  logic w_any_req;
  logic w_pick_m1;
  logic w_in_req;
  logic w_in_rdata;
  logic w_mem_acc;
  logic w_rd_done;
  logic w_complete;
  logic w_timeout;
  logic w_finish;
  logic w_ack;
  logic w_valid;

  assign w_any_req  = pil_m0_mem_req | pil_m1_mem_req;
  // m1 wins when alone or when it holds the round-robin priority.
  assign w_pick_m1  = pil_m1_mem_req & (~pil_m0_mem_req | r_rr_ptr);
  assign w_in_req   = (r_state == S_REQ);
  assign w_in_rdata = (r_state == S_RDATA);
  assign w_mem_acc  = w_in_req & pil_mem_ack;
  assign w_rd_done  = (w_mem_acc & ~r_wen & pil_mem_valid) | (w_in_rdata & pil_mem_valid);
  assign w_complete = (w_mem_acc & r_wen) | w_rd_done;
  assign w_finish   = w_complete | w_timeout;

`ifdef SVX32_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_to_cnt;

  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  // A completion landing on the limit cycle takes precedence over the abort.
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_complete;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_ack            = 1'b0;
    w_valid          = 1'b0;
    pol_mem_req      = 1'b0;
    pol_timeout      = 1'b0;
    pol_m0_mem_ack   = 1'b0;
    pol_m1_mem_ack   = 1'b0;
    pol_m0_mem_valid = 1'b0;
    pol_m1_mem_valid = 1'b0;
    pov_m0_mem_rdata = '0;
    pov_m1_mem_rdata = '0;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_REQ;
      S_REQ:   if (w_finish) w_next_state = S_IDLE;
               else if (w_mem_acc) w_next_state = S_RDATA;
      S_RDATA: if (w_finish) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    pol_mem_req = w_in_req;
    pol_timeout = w_timeout;
    // An abort still hands the winner its ack, plus a zero-data valid for reads.
    w_ack       = w_mem_acc | (w_timeout & w_in_req);
    w_valid     = w_rd_done | (w_timeout & ~r_wen);
    pol_m0_mem_ack   = w_ack & r_grant[0];
    pol_m1_mem_ack   = w_ack & r_grant[1];
    pol_m0_mem_valid = w_valid & r_grant[0];
    pol_m1_mem_valid = w_valid & r_grant[1];
    if (w_rd_done && r_grant[0]) pov_m0_mem_rdata = piv_mem_rdata;
    if (w_rd_done && r_grant[1]) pov_m1_mem_rdata = piv_mem_rdata;
  end

  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_grant    <= 2'b00;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_byte_sel <= '0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_grant    <= w_pick_m1 ? 2'b10 : 2'b01;
      r_wen      <= w_pick_m1 ? pil_m1_mem_wen      : pil_m0_mem_wen;
      r_addr     <= w_pick_m1 ? piv_m1_mem_addr     : piv_m0_mem_addr;
      r_wdata    <= w_pick_m1 ? piv_m1_mem_wdata    : piv_m0_mem_wdata;
      r_byte_sel <= w_pick_m1 ? piv_m1_mem_byte_sel : piv_m0_mem_byte_sel;
    end else if (w_finish) begin
      r_grant  <= 2'b00;
      r_rr_ptr <= ~r_grant[1];
    end
  end

  assign pol_mem_wen      = r_wen;
  assign pov_mem_addr     = r_addr;
  assign pov_mem_wdata    = r_wdata;
  assign pov_mem_byte_sel = r_byte_sel;
  assign pov_grant        = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_svx32_dmem_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_svx32_dmem_arbiter
// Brief    : Self-checking bench for svx32_dmem_arbiter (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_svx32_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic pil_clk = 1'b0;
  logic pil_rst_n = 1'b0;
  logic pil_m0_mem_req, pil_m0_mem_wen, pil_m1_mem_req, pil_m1_mem_wen;
  logic [AW-1:0] piv_m0_mem_addr, piv_m1_mem_addr;
  logic [DW-1:0] piv_m0_mem_wdata, piv_m1_mem_wdata;
  logic [BW-1:0] piv_m0_mem_byte_sel, piv_m1_mem_byte_sel;
  logic pol_m0_mem_ack, pol_m0_mem_valid, pol_m1_mem_ack, pol_m1_mem_valid;
  logic [DW-1:0] pov_m0_mem_rdata, pov_m1_mem_rdata;
  logic pol_mem_req, pol_mem_wen;
  logic [AW-1:0] pov_mem_addr;
  logic [DW-1:0] pov_mem_wdata;
  logic [BW-1:0] pov_mem_byte_sel;
  logic pil_mem_ack, pil_mem_valid;
  logic [DW-1:0] piv_mem_rdata;
  logic [1:0] pov_grant;
  logic pol_timeout;

  always #5 pil_clk = ~pil_clk;

  svx32_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) u_dut (
    .pil_clk(pil_clk), .pil_rst_n(pil_rst_n),
    .pil_m0_mem_req(pil_m0_mem_req), .pil_m0_mem_wen(pil_m0_mem_wen),
    .piv_m0_mem_addr(piv_m0_mem_addr), .piv_m0_mem_wdata(piv_m0_mem_wdata),
    .piv_m0_mem_byte_sel(piv_m0_mem_byte_sel),
    .pol_m0_mem_ack(pol_m0_mem_ack), .pol_m0_mem_valid(pol_m0_mem_valid),
    .pov_m0_mem_rdata(pov_m0_mem_rdata),
    .pil_m1_mem_req(pil_m1_mem_req), .pil_m1_mem_wen(pil_m1_mem_wen),
    .piv_m1_mem_addr(piv_m1_mem_addr), .piv_m1_mem_wdata(piv_m1_mem_wdata),
    .piv_m1_mem_byte_sel(piv_m1_mem_byte_sel),
    .pol_m1_mem_ack(pol_m1_mem_ack), .pol_m1_mem_valid(pol_m1_mem_valid),
    .pov_m1_mem_rdata(pov_m1_mem_rdata),
    .pol_mem_req(pol_mem_req), .pol_mem_wen(pol_mem_wen),
    .pov_mem_addr(pov_mem_addr), .pov_mem_wdata(pov_mem_wdata),
    .pov_mem_byte_sel(pov_mem_byte_sel),
    .pil_mem_ack(pil_mem_ack), .pil_mem_valid(pil_mem_valid),
    .piv_mem_rdata(piv_mem_rdata),
    .pov_grant(pov_grant), .pol_timeout(pol_timeout)
  );

  // Per-master response bundles and the downstream bundle, for compact compares.
  wire [DW+1:0] w_m0 = {pol_m0_mem_ack, pol_m0_mem_valid, pov_m0_mem_rdata};
  wire [DW+1:0] w_m1 = {pol_m1_mem_ack, pol_m1_mem_valid, pov_m1_mem_rdata};
  wire [AW+DW+BW+1:0] w_dn = {pol_mem_req, pol_mem_wen, pov_mem_addr, pov_mem_wdata, pov_mem_byte_sel};

  int checks = 0;
  int failures = 0;
  int exp_prio;  // model: master that wins when both request

  task automatic tick();
    @(posedge pil_clk);
    #1;
  endtask

  task automatic idle_inputs();
    pil_m0_mem_req = 0; pil_m0_mem_wen = 0; piv_m0_mem_addr = '0; piv_m0_mem_wdata = '0;
    piv_m0_mem_byte_sel = '0;
    pil_m1_mem_req = 0; pil_m1_mem_wen = 0; piv_m1_mem_addr = '0; piv_m1_mem_wdata = '0;
    piv_m1_mem_byte_sel = '0;
    pil_mem_ack = 0; pil_mem_valid = 0; piv_mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    pil_rst_n = 0;
    repeat (2) @(posedge pil_clk);
    #1;
    pil_rst_n = 1;
    exp_prio = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (pov_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", pov_grant); end
    checks++; if (w_dn !== '0) begin failures++; $display("FAIL reset_downstream got=%h exp=0", w_dn); end
    checks++; if ({w_m0, w_m1, pol_timeout} !== '0) begin failures++; $display("FAIL reset_master_out got=%h exp=0", {w_m0, w_m1, pol_timeout}); end
  endtask

  task automatic test_single_read();
    apply_reset();
    pil_m0_mem_req = 1; pil_m0_mem_wen = 0; piv_m0_mem_addr = 32'h100; piv_m0_mem_byte_sel = 4'hF;
    #1;
    checks++; if (pol_mem_req !== 1'b0) begin failures++; $display("FAIL rd_req_latency got=%b exp=0", pol_mem_req); end
    tick(); #1;
    checks++; if ({pol_mem_req, pol_mem_wen, pov_mem_addr, pov_grant} !== {1'b1, 1'b0, 32'h100, 2'b01})
      begin failures++; $display("FAIL rd_issue got=%b/%b/%h/%b exp=1/0/100/01", pol_mem_req, pol_mem_wen, pov_mem_addr, pov_grant); end
    tick(); pil_mem_ack = 1; #1;
    checks++; if ({pol_m0_mem_ack, pol_m1_mem_ack} !== 2'b10) begin failures++; $display("FAIL rd_ack got=%b%b exp=10", pol_m0_mem_ack, pol_m1_mem_ack); end
    tick(); pil_mem_ack = 0; pil_m0_mem_req = 0; #1;
    checks++; if ({pol_mem_req, pol_m0_mem_ack} !== 2'b00) begin failures++; $display("FAIL rd_req_drop got=%b%b exp=00", pol_mem_req, pol_m0_mem_ack); end
    tick();
    tick(); pil_mem_valid = 1; piv_mem_rdata = 32'hCAFEF00D; #1;
    checks++; if (w_m0 !== {1'b0, 1'b1, 32'hCAFEF00D}) begin failures++; $display("FAIL rd_valid_m0 got=%h exp=%h", w_m0, {2'b01, 32'hCAFEF00D}); end
    checks++; if (w_m1 !== '0) begin failures++; $display("FAIL rd_valid_m1 got=%h exp=0", w_m1); end
    tick(); pil_mem_valid = 0; #1;
    checks++; if ({pov_grant, pol_m0_mem_valid} !== 3'b000) begin failures++; $display("FAIL rd_done got=%b/%b exp=00/0", pov_grant, pol_m0_mem_valid); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    pil_m0_mem_req = 1; pil_m0_mem_wen = 1; piv_m0_mem_addr = 32'h10;
    pil_m1_mem_req = 1; pil_m1_mem_wen = 1; piv_m1_mem_addr = 32'h20;
    tick(); pil_mem_ack = 1; #1;
    checks++; if ({pov_grant, pov_mem_addr, pol_m0_mem_ack} !== {2'b01, 32'h10, 1'b1})
      begin failures++; $display("FAIL rr_first got=%b/%h/%b exp=01/10/1", pov_grant, pov_mem_addr, pol_m0_mem_ack); end
    tick(); pil_mem_ack = 0; pil_m0_mem_req = 0; #1;
    checks++; if (pov_grant !== 2'b00) begin failures++; $display("FAIL rr_gap got=%b exp=00", pov_grant); end
    pil_m0_mem_req = 1;
    tick(); pil_mem_ack = 1; #1;
    checks++; if ({pov_grant, pov_mem_addr, pol_m1_mem_ack, pol_m0_mem_ack} !== {2'b10, 32'h20, 2'b10})
      begin failures++; $display("FAIL rr_second got=%b/%h/%b%b exp=10/20/10", pov_grant, pov_mem_addr, pol_m1_mem_ack, pol_m0_mem_ack); end
    tick(); pil_mem_ack = 0;
    tick(); pil_mem_ack = 1; #1;
    checks++; if (pov_grant !== 2'b01) begin failures++; $display("FAIL rr_third got=%b exp=01", pov_grant); end
    tick(); idle_inputs();
  endtask

  task automatic test_write();
    apply_reset();
    pil_m1_mem_req = 1; pil_m1_mem_wen = 1; piv_m1_mem_addr = 32'h40;
    piv_m1_mem_wdata = 32'hA5A5A5A5; piv_m1_mem_byte_sel = 4'b0011;
    piv_m0_mem_addr = 32'hFFFF0000; piv_m0_mem_wdata = 32'h11111111; piv_m0_mem_byte_sel = 4'hF;
    tick(); pil_mem_ack = 1; pil_mem_valid = 1; piv_mem_rdata = 32'h5555AAAA; #1;
    checks++; if (w_dn !== {1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b0011}) begin failures++; $display("FAIL wr_downstream got=%h", w_dn); end
    checks++; if ({pov_grant, pol_m1_mem_ack, pol_m0_mem_ack} !== 4'b1010) begin failures++; $display("FAIL wr_ack got=%b/%b%b exp=10/10", pov_grant, pol_m1_mem_ack, pol_m0_mem_ack); end
    checks++; if ({pol_m1_mem_valid, pov_m1_mem_rdata} !== '0) begin failures++; $display("FAIL wr_no_valid got=%b/%h exp=0/0", pol_m1_mem_valid, pov_m1_mem_rdata); end
    tick(); idle_inputs(); #1;
    checks++; if ({pov_grant, pol_mem_req, pol_m1_mem_ack} !== 4'b0000) begin failures++; $display("FAIL wr_idle got=%b/%b/%b exp=00/0/0", pov_grant, pol_mem_req, pol_m1_mem_ack); end
  endtask

  task automatic test_fast_read_and_stray();
    apply_reset();
    pil_m0_mem_req = 1; piv_m0_mem_addr = 32'h200;
    tick(); pil_mem_ack = 1; pil_mem_valid = 1; piv_mem_rdata = 32'h12345678; #1;
    checks++; if (w_m0 !== {2'b11, 32'h12345678}) begin failures++; $display("FAIL fast_rd got=%h exp=%h", w_m0, {2'b11, 32'h12345678}); end
    tick(); idle_inputs(); #1;
    checks++; if (pov_grant !== 2'b00) begin failures++; $display("FAIL fast_rd_idle got=%b exp=00", pov_grant); end
    pil_mem_ack = 1; pil_mem_valid = 1; piv_mem_rdata = 32'hFFFFFFFF; #1;
    checks++; if ({w_m0, w_m1} !== '0) begin failures++; $display("FAIL stray_idle got=%h exp=0", {w_m0, w_m1}); end
    tick(); idle_inputs(); #1;
    checks++; if ({pov_grant, pol_mem_req} !== 3'b000) begin failures++; $display("FAIL stray_fsm got=%b/%b exp=00/0", pov_grant, pol_mem_req); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pil_m0_mem_req = 1;
    tick(); pil_mem_ack = 1;
    tick(); pil_mem_ack = 0; pil_m0_mem_req = 0; #1;
    checks++; if (pov_grant !== 2'b01) begin failures++; $display("FAIL rst_pre_grant got=%b exp=01", pov_grant); end
    pil_rst_n = 0; #1;
    checks++; if ({pov_grant, pol_mem_req, pol_m0_mem_ack, pol_m1_mem_ack} !== 5'b0) begin failures++; $display("FAIL rst_rdata got=%b/%b/%b%b exp=0", pov_grant, pol_mem_req, pol_m0_mem_ack, pol_m1_mem_ack); end
    pil_rst_n = 1; exp_prio = 0;
    tick(); pil_mem_valid = 1; piv_mem_rdata = 32'hBADBAD00; #1;
    checks++; if ({w_m0, w_m1, pov_grant} !== '0) begin failures++; $display("FAIL rst_late_valid got=%h exp=0", {w_m0, w_m1, pov_grant}); end
    tick(); pil_mem_valid = 0; pil_m0_mem_req = 1;
    tick(); pil_mem_ack = 1; #1;
    checks++; if ({pol_mem_req, pol_m0_mem_ack} !== 2'b11) begin failures++; $display("FAIL rst_req_pre got=%b%b exp=11", pol_mem_req, pol_m0_mem_ack); end
    pil_m0_mem_req = 0; pil_rst_n = 0; #1;
    checks++; if ({pol_mem_req, pol_m0_mem_ack} !== 2'b00) begin failures++; $display("FAIL rst_req_drop got=%b%b exp=00", pol_mem_req, pol_m0_mem_ack); end
    pil_mem_ack = 0; pil_rst_n = 1;
    tick(); #1;
    checks++; if ({pov_grant, pol_mem_req} !== 3'b000) begin failures++; $display("FAIL rst_after got=%b/%b exp=00/0", pov_grant, pol_mem_req); end
  endtask

`ifdef SVX32_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    int at;
    seen = 0; at = -1;
    apply_reset();
    pil_m0_mem_req = 1; piv_m0_mem_addr = 32'h300; piv_mem_rdata = 32'hDEADBEEF;
    tick();
    for (int c = 0; c < 3 * TO; c++) begin
      #1;
      if (pol_timeout) begin
        seen++;
        if (at < 0) at = c;
        checks++; if (w_m0 !== {2'b11, 32'h0}) begin failures++; $display("FAIL to_winner got=%h exp=%h", w_m0, {2'b11, 32'h0}); end
        pil_m0_mem_req = 0;
      end
      tick();
    end
    checks++; if (at != TO - 1 || seen != 1) begin failures++; $display("FAIL to_pulse got_at=%0d got_cnt=%0d exp_at=%0d exp_cnt=1", at, seen, TO - 1); end
    pil_m1_mem_req = 1; pil_m1_mem_wen = 1;
    tick(); pil_mem_ack = 1; #1;
    checks++; if ({pov_grant, pol_m1_mem_ack, pol_timeout} !== 4'b1010) begin failures++; $display("FAIL to_next got=%b/%b/%b exp=10/1/0", pov_grant, pol_m1_mem_ack, pol_timeout); end
    tick(); idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [1:0] sel;
    int w, ad, vd;
    logic fin, fastv, v, rd_q;
    logic wen_m[2];
    logic [AW-1:0] addr_m[2];
    logic [DW-1:0] wd_m[2];
    logic [BW-1:0] bs_m[2];
    logic [DW-1:0] rd;
    logic [DW+1:0] exp_out, exp0, exp1;
    logic [AW+DW+BW+1:0] exp_dn;
    apply_reset();
    for (int it = 0; it < 200; it++) begin
      sel = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        wen_m[m] = 1'($urandom_range(0, 1)); addr_m[m] = $urandom; wd_m[m] = $urandom; bs_m[m] = BW'($urandom);
      end
      pil_m0_mem_req = sel[0]; pil_m0_mem_wen = wen_m[0]; piv_m0_mem_addr = addr_m[0];
      piv_m0_mem_wdata = wd_m[0]; piv_m0_mem_byte_sel = bs_m[0];
      pil_m1_mem_req = sel[1]; pil_m1_mem_wen = wen_m[1]; piv_m1_mem_addr = addr_m[1];
      piv_m1_mem_wdata = wd_m[1]; piv_m1_mem_byte_sel = bs_m[1];
      w = (sel == 2'b11) ? exp_prio : (sel[0] ? 0 : 1);
      ad = $urandom_range(0, 3); vd = $urandom_range(0, 3); rd = $urandom;
      rd_q = !wen_m[w];
      exp_dn = {1'b1, wen_m[w], addr_m[w], wd_m[w], bs_m[w]};
      tick();
      for (int d = 0; d <= ad; d++) begin
        fin = (d == ad);
        fastv = fin && rd_q && (vd == 0);
        pil_mem_ack = fin;
        pil_mem_valid = fastv || (!rd_q && ($urandom_range(0, 1) == 1));
        piv_mem_rdata = fastv ? rd : $urandom;
        #1;
        exp_out = {fin, fastv, fastv ? rd : 32'h0};
        exp0 = (w == 0) ? exp_out : '0;
        exp1 = (w == 1) ? exp_out : '0;
        checks++; if (pov_grant !== ((w == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rnd_grant it=%0d got=%b exp_owner=m%0d", it, pov_grant, w); end
        checks++; if (w_dn !== exp_dn) begin failures++; $display("FAIL rnd_downstream it=%0d got=%h exp=%h", it, w_dn, exp_dn); end
        checks++; if ({w_m0, w_m1} !== {exp0, exp1}) begin failures++; $display("FAIL rnd_req_resp it=%0d got=%h/%h exp=%h/%h", it, w_m0, w_m1, exp0, exp1); end
        tick();
      end
      pil_mem_ack = 0; pil_mem_valid = 0; pil_m0_mem_req = 0; pil_m1_mem_req = 0;
      if (rd_q && vd > 0) begin
        for (int k = 1; k <= vd; k++) begin
          v = (k == vd);
          pil_mem_valid = v;
          piv_mem_rdata = v ? rd : $urandom;
          #1;
          exp_out = {1'b0, v, v ? rd : 32'h0};
          exp0 = (w == 0) ? exp_out : '0;
          exp1 = (w == 1) ? exp_out : '0;
          checks++; if ({pol_mem_req, w_m0, w_m1} !== {1'b0, exp0, exp1}) begin failures++; $display("FAIL rnd_rdata it=%0d got=%b/%h/%h exp=0/%h/%h", it, pol_mem_req, w_m0, w_m1, exp0, exp1); end
          tick();
        end
        pil_mem_valid = 0;
      end
      exp_prio = 1 - w;
      #1;
      checks++; if ({pov_grant, pol_mem_req, pol_timeout} !== 4'b0000) begin failures++; $display("FAIL rnd_idle it=%0d got=%b/%b/%b exp=00/0/0", it, pov_grant, pol_mem_req, pol_timeout); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_fast_read_and_stray();
    test_reset_mid();
`ifdef SVX32_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
